// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the host command, hazard-detect and stage-control
// signals exchanged between the pipeline controller and the rest of the core.
//   master : host / datapath side (drives commands and hazard inputs)
//   slave  : pipe_ctrl side (drives pipeline_en, pause/flush, status)
interface pipe_ctrl_if #(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
);
    // host commands
    logic              host_run;
    logic              host_halt;
    logic              host_step;
    logic [STEP_W-1:0] host_step_cnt;
    // hazard sources
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              imem_wait;
    logic              dmem_wait;
    // stage controls and status
    logic              pipeline_en;
    logic              pc_pause;
    logic              if_id_pause;
    logic              if_id_flush;
    logic              id_ex_pause;
    logic              id_ex_flush;
    logic              back_pause;
    logic              halted;
    logic [STEP_W-1:0] steps_left;
    logic [CNT_W-1:0]  adv_cnt;

    modport master (
        output host_run, host_halt, host_step, host_step_cnt,
        output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
        output imem_wait, dmem_wait,
        input  pipeline_en, pc_pause, if_id_pause, if_id_flush,
        input  id_ex_pause, id_ex_flush, back_pause, halted,
        input  steps_left, adv_cnt
    );

    modport slave (
        input  host_run, host_halt, host_step, host_step_cnt,
        input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
        input  imem_wait, dmem_wait,
        output pipeline_en, pc_pause, if_id_pause, if_id_flush,
        output id_ex_pause, id_ex_flush, back_pause, halted,
        output steps_left, adv_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller for the five-stage RV64 core.
// Sequences run / halt / N-cycle single-step from host commands and turns
// memory-wait, taken-branch and load-use hazards into per-stage pause and
// flush controls.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset (returns to HALT, clears counters)
//   bus  - pipe_ctrl_if.slave: host commands, hazard inputs, stage controls,
//          halted / steps_left / adv_cnt status
module pipe_ctrl #(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] steps_left, steps_nxt;
    logic [CNT_W-1:0]  adv_cnt;
    logic              pipeline_en;
    logic              mem_wait;
    logic              advance;
    logic              load_use;

    // Moore enable: host commands reach the pipeline one cycle later.
    assign pipeline_en = (state == RUN) || (state == STEP);
    assign mem_wait    = bus.imem_wait | bus.dmem_wait;
    assign advance     = pipeline_en & ~mem_wait;

    // x0 is hard-wired zero, so a load to it never creates a dependency.
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HALT;
            steps_left <= '0;
            adv_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            steps_left <= steps_nxt;
            if (advance)
                adv_cnt <= adv_cnt + CNT_W'(1);
        end
    end

    // Command priority: halt > run > step.
    always_comb begin
        state_nxt = state;
        steps_nxt = steps_left;
        if (bus.host_halt) begin
            state_nxt = HALT;
            steps_nxt = '0;
        end else begin
            case (state)
                HALT: begin
                    if (bus.host_run) begin
                        state_nxt = RUN;
                    end else if (bus.host_step && (bus.host_step_cnt != '0)) begin
                        state_nxt = STEP;
                        steps_nxt = bus.host_step_cnt;
                    end
                end
                RUN: begin
                    if (!bus.host_run)
                        state_nxt = HALT;
                end
                STEP: begin
                    if (bus.host_run) begin
                        state_nxt = RUN;
                        steps_nxt = '0;
                    end else if (advance) begin
                        // Only real advances consume a step; wait cycles do not.
                        if (steps_left == STEP_W'(1)) begin
                            state_nxt = HALT;
                            steps_nxt = '0;
                        end else begin
                            steps_nxt = steps_left - STEP_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = HALT;
                    steps_nxt = '0;
                end
            endcase
        end
    end

    // Stage registers honour flush even while disabled, so every hazard
    // control is gated off when the pipeline is not enabled.
    always_comb begin
        bus.pc_pause    = 1'b0;
        bus.if_id_pause = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_pause = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.back_pause  = 1'b0;
        if (pipeline_en) begin
            if (mem_wait) begin
                bus.pc_pause    = 1'b1;
                bus.if_id_pause = 1'b1;
                bus.id_ex_pause = 1'b1;
                bus.back_pause  = 1'b1;
            end else if (bus.ex_branch_taken) begin
                // The ID instruction is squashed, so load-use is moot.
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
            end else if (load_use) begin
                bus.pc_pause    = 1'b1;
                bus.if_id_pause = 1'b1;
                bus.id_ex_flush = 1'b1;
            end
        end
    end

    assign bus.pipeline_en = pipeline_en;
    assign bus.halted      = (state == HALT);
    assign bus.steps_left  = steps_left;
    assign bus.adv_cnt     = adv_cnt;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline controller for the five-stage RV64 core on NetFPGA.
- Owns the global pipeline_en, plus the pause and flush controls for PC, IF/ID, ID/EX and the later stage registers.
- Sequences run, halt and N-cycle single-step from host registers.
- Resolves load-use, taken-branch and memory-wait hazards into per-stage stall/bubble controls.

Parameters:
STEP_W, 16, width of host step count and internal step counter
CNT_W, 32, width of advance (cycle) counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
host_run  in  1  level; request free-run
host_halt  in  1  pulse; force halt
host_step  in  1  pulse; start N-cycle step
host_step_cnt  in  STEP_W  N, sampled with host_step
id_rs1  in  5  ID-stage source reg 1
id_rs2  in  5  ID-stage source reg 2
ex_rd  in  5  EX-stage destination reg
ex_mem_read  in  1  EX-stage instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump
imem_wait  in  1  instruction memory not ready
dmem_wait  in  1  data memory not ready
pipeline_en  out  1  global pipeline advance enable
pc_pause  out  1  hold PC
if_id_pause  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_pause  out  1  hold ID/EX
id_ex_flush  out  1  load bubble into ID/EX
back_pause  out  1  hold EX/MEM and MEM/WB
halted  out  1  FSM in HALT
steps_left  out  STEP_W  remaining step advances
adv_cnt  out  CNT_W  count of real pipeline advances

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: state=HALT, steps_left=0, adv_cnt=0.
  - Consequently pipeline_en=0, halted=1, and all pause/flush outputs=0.
  - Reset mid-RUN or mid-STEP goes to HALT on the next edge and discards the pending step count.
- FSM states: HALT, RUN, STEP (registered). pipeline_en = (state==RUN)|(state==STEP), Moore, so one cycle latency from host input to pipeline_en.
- Host command priority each cycle: host_halt > host_run > host_step.
  - Any state with host_halt -> HALT, steps_left=0.
  - HALT with host_run=1 -> RUN.
  - RUN with host_run=0 -> HALT.
  - HALT with host_step=1, host_run=0 and host_step_cnt!=0 -> STEP, steps_left=host_step_cnt.
  - host_step_cnt==0 is ignored (stay HALT).
  - host_step in RUN or STEP is ignored.
  - STEP with host_run=1 -> RUN, steps_left=0.
- mem_wait = imem_wait|dmem_wait. advance = pipeline_en & ~mem_wait.
- In STEP: steps_left decrements only on advance. An advance with steps_left==1 -> HALT, steps_left=0. Wait cycles do not consume steps.
- adv_cnt increments on every advance and wraps modulo 2^CNT_W.
- Hazard outputs are combinational from the current inputs and are forced to 0 when pipeline_en=0.
  - This is required because the stage registers honour flush even when pipeline_en=0, so a halted pipeline would otherwise be corrupted.
- Priority with pipeline_en=1:
  1. mem_wait=1: pc_pause, if_id_pause, id_ex_pause, back_pause=1; all flushes=0 (full freeze).
  2. Otherwise ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, all pauses=0. Branch beats load-use because the ID instruction is squashed.
  3. Otherwise load-use: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) -> pc_pause=1, if_id_pause=1, id_ex_flush=1. id_ex_pause=0, back_pause=0.
  4. Otherwise all 0.
- ex_rd==0 never triggers load-use.
- A load-use stall counts as an advance (the back stages move).
- halted = (state==HALT).

Test Plan:
- Reset then idle -> pipeline_en=0, halted=1, adv_cnt=0, all pause/flush=0. Drive ex_branch_taken=1 while halted -> if_id_flush stays 0.
- Pulse host_step with cnt=3, no waits -> pipeline_en high exactly 3 cycles starting the cycle after the pulse; steps_left 3,2,1; then HALT; adv_cnt=3.
- Step cnt=2 with dmem_wait=1 for 4 cycles inside the window -> pipeline_en high 6 cycles; all pauses=1 during the wait; adv_cnt=2.
- RUN with ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_pause=1, if_id_pause=1, id_ex_flush=1. Same with ex_rd=0 -> all 0.
- RUN with load-use plus ex_branch_taken in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_pause=0. Add imem_wait=1 -> full freeze, flushes=0.
- STEP cnt=100, after 10 advances assert host_halt together with host_run -> HALT next cycle, steps_left=0. Same cycle with rst mid-step -> HALT, adv_cnt=0.
